// File: rtl/sap_ram16x8.sv
// -----------------------------------------------------------------------------
// sap_ram16x8
//   16 x 8 program/data RAM for an SAP-style datapath. It has two modes:
//   - Program mode (prog=1): an external loader writes bytes through a
//     strobe/acknowledge handshake. A write pointer auto-increments after
//     each write and can be preloaded from addr.
//   - Run mode (prog=0): registered reads at addr, with a one-cycle valid
//     pulse for each read.
//
// Optional feature (macro SAP_RAM_PARITY_EN):
//   Each word stores a ninth even-parity bit. The macro adds the par_inj input
//   and the ram_perr output.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset; has priority over all inputs
//   prog       in   1 = program mode, 0 = run mode
//   addr       in   [AW] read address (from the MAR); also the pointer preload value
//   ce         in   run-mode read enable; one read per cycle while high
//   ld_ptr     in   program mode: load the write pointer from addr
//   wr_stb     in   loader write strobe; already synchronous to clk
//   wr_data    in   [DW] byte to write
//   par_inj    in   (parity build) invert the stored parity bit of this write
//   wr_ack     out  high from the write cycle until wr_stb is seen low
//   ptr        out  [AW] current loader write pointer
//   wrap       out  one-cycle pulse when the pointer wraps from 15 to 0
//   ram_out    out  [DW] registered read data; holds its value between reads
//   ram_valid  out  one-cycle pulse per completed read
//   ram_perr   out  (parity build) parity mismatch on the read data
// -----------------------------------------------------------------------------
module sap_ram16x8 #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog,
  input  logic [AW-1:0] addr,
  input  logic          ce,
  input  logic          ld_ptr,
  input  logic          wr_stb,
  input  logic [DW-1:0] wr_data,
`ifdef SAP_RAM_PARITY_EN
  input  logic          par_inj,
  output logic          ram_perr,
`endif
  output logic          wr_ack,
  output logic [AW-1:0] ptr,
  output logic          wrap,
  output logic [DW-1:0] ram_out,
  output logic          ram_valid
);

  localparam int DEPTH = 2 ** AW;
`ifdef SAP_RAM_PARITY_EN
  localparam int MW = DW + 1;   // parity bit is stored in the MSB
`else
  localparam int MW = DW;
`endif

  typedef enum logic {
    S_IDLE,
    S_WR_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [MW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_ptr;
  logic          r_wr_ack;
  logic          r_wrap;
  logic          r_stb_q;       // wr_stb value at the previous edge
  logic          r_stb_armed;   // wr_stb has been seen low since reset
  logic [DW-1:0] r_ram_out;
  logic          r_ram_valid;

  logic          w_stb_edge;
  logic          w_wr_en;
  logic          w_ld_en;
  logic [AW-1:0] w_wr_addr;
  logic [MW-1:0] w_wr_word;
  logic [MW-1:0] w_rd_word;
  logic          w_rd_en;

  // The history register is cleared by reset. On its own, that would make a
  // strobe held high through reset look like a new edge on the first cycle
  // after reset. The armed flag blocks this: an edge counts only after
  // wr_stb has been sampled low at least once outside reset.
  assign w_stb_edge = wr_stb & ~r_stb_q & r_stb_armed;
  assign w_rd_en    = ~prog & ce;
  assign w_rd_word  = r_mem[addr];

`ifdef SAP_RAM_PARITY_EN
  assign w_wr_word = {(^wr_data) ^ par_inj, wr_data};
`else
  assign w_wr_word = wr_data;
`endif

  // ---------------------------------------------------------------------------
  // Handshake FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM: next state and write/load controls
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first. Without the
  // defaults, any path that skips an assignment would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_ld_en     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (prog) begin
          w_ld_en = ld_ptr;
          if (w_stb_edge) begin
            w_wr_en     = 1'b1;
            w_state_nxt = S_WR_HOLD;
          end
        end
      end
      S_WR_HOLD: begin
        if (!wr_stb || !prog) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A pointer load in the same cycle as a write redirects that write.
    w_wr_addr = w_ld_en ? addr : r_ptr;
  end

  // ---------------------------------------------------------------------------
  // Pointer, acknowledge, wrap pulse and strobe history
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together at the edge, whatever order the code is written in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_wr_ack    <= 1'b0;
      r_wrap      <= 1'b0;
      r_stb_q     <= 1'b0;
      r_stb_armed <= 1'b0;
    end else begin
      r_stb_q  <= wr_stb;
      if (!wr_stb) r_stb_armed <= 1'b1;
      r_wr_ack <= (w_state_nxt == S_WR_HOLD);
      r_wrap   <= 1'b0;
      if (w_wr_en) begin
        r_ptr  <= w_wr_addr + AW'(1);
        r_wrap <= (w_wr_addr == {AW{1'b1}});
      end else if (w_ld_en) begin
        r_ptr  <= addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array is built from flops so that reset can clear every word.
  // A macro SRAM could not be cleared this way, and its contents would be
  // left undefined after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Run-mode registered read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ram_out   <= '0;
      r_ram_valid <= 1'b0;
    end else begin
      r_ram_valid <= w_rd_en;
      if (w_rd_en) r_ram_out <= w_rd_word[DW-1:0];
    end
  end

`ifdef SAP_RAM_PARITY_EN
  logic r_ram_perr;

  // Even parity over data and stored bit: a nonzero XOR means a mismatch.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_ram_perr <= 1'b0;
    else if (w_rd_en) r_ram_perr <= ^w_rd_word;
    else              r_ram_perr <= 1'b0;
  end

  assign ram_perr = r_ram_perr;
`endif

  assign wr_ack    = r_wr_ack;
  assign ptr       = r_ptr;
  assign wrap      = r_wrap;
  assign ram_out   = r_ram_out;
  assign ram_valid = r_ram_valid;

endmodule

// File: tb/tb_sap_ram16x8.sv
// -----------------------------------------------------------------------------
// tb_sap_ram16x8
//   Directed testbench for sap_ram16x8. Each scenario task drives its own
//   stimulus and compares the outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_sap_ram16x8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog;
  logic [3:0] addr;
  logic       ce;
  logic       ld_ptr;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [3:0] ptr;
  logic       wrap;
  logic [7:0] ram_out;
  logic       ram_valid;
`ifdef SAP_RAM_PARITY_EN
  logic       par_inj;
  logic       ram_perr;
`endif

  int vectors     = 0;
  int miscompares = 0;

  sap_ram16x8 #(.DW(8), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog      (prog),
    .addr      (addr),
    .ce        (ce),
    .ld_ptr    (ld_ptr),
    .wr_stb    (wr_stb),
    .wr_data   (wr_data),
`ifdef SAP_RAM_PARITY_EN
    .par_inj   (par_inj),
    .ram_perr  (ram_perr),
`endif
    .wr_ack    (wr_ack),
    .ptr       (ptr),
    .wrap      (wrap),
    .ram_out   (ram_out),
    .ram_valid (ram_valid)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge. Inputs are driven here and
  // outputs are sampled here, 1 ns away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single clean strobe pulse: rise for one cycle, then low for one cycle.
  task automatic strobe(input logic [7:0] d);
    wr_data = d;
    wr_stb  = 1'b1;
    tick();
    wr_stb  = 1'b0;
    tick();
  endtask

  // Run-mode read of one address, then compare the data and the valid pulse.
  task automatic read_chk(input logic [3:0] a, input logic [7:0] exp, input string nm);
    prog = 1'b0; ce = 1'b1; addr = a;
    tick();
    ce = 1'b0;
    vectors++;
    if (ram_out !== exp || ram_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: ram_out=%h valid=%b, expected %h valid=1", nm, ram_out, ram_valid, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b1; addr = 4'd7;
    tick(); tick();
    vectors++;
    if (ram_out !== 8'h00 || ram_valid !== 1'b0 || ptr !== 4'd0 || wr_ack !== 1'b0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: out=%h valid=%b ptr=%0d ack=%b wrap=%b, expected 00 0 0 0 0",
               ram_out, ram_valid, ptr, wr_ack, wrap);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (ram_out !== 8'h00 || ram_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL first_read: out=%h valid=%b, expected 00 1", ram_out, ram_valid);
    end
    ce = 1'b0;
    tick();
    vectors++;
    if (ram_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_pulse: valid=%b, expected 0", ram_valid);
    end
  endtask

  task automatic test_load_wrap();
    prog = 1'b1; ld_ptr = 1'b1; addr = 4'd14;
    tick();
    ld_ptr = 1'b0;
    vectors++;
    if (ptr !== 4'd14) begin
      miscompares++;
      $display("FAIL ld_ptr: ptr=%0d, expected 14", ptr);
    end
    wr_data = 8'hA5; wr_stb = 1'b1;
    tick();
    vectors++;
    if (ptr !== 4'd15 || wrap !== 1'b0 || wr_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL write14: ptr=%0d wrap=%b ack=%b, expected 15 0 1", ptr, wrap, wr_ack);
    end
    wr_stb = 1'b0;
    tick();
    vectors++;
    if (wr_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_drop: ack=%b, expected 0", wr_ack);
    end
    wr_data = 8'h3C; wr_stb = 1'b1;
    tick();
    vectors++;
    if (ptr !== 4'd0 || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap: ptr=%0d wrap=%b, expected 0 1", ptr, wrap);
    end
    wr_stb = 1'b0;
    tick();
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_pulse: wrap=%b, expected 0", wrap);
    end
    // Pointer load and strobe edge in the same cycle.
    ld_ptr = 1'b1; addr = 4'd9; wr_data = 8'h5A; wr_stb = 1'b1;
    tick();
    ld_ptr = 1'b0; wr_stb = 1'b0;
    vectors++;
    if (ptr !== 4'd10) begin
      miscompares++;
      $display("FAIL ld_and_write: ptr=%0d, expected 10", ptr);
    end
    tick();
    read_chk(4'd14, 8'hA5, "read14");
    read_chk(4'd15, 8'h3C, "read15");
    read_chk(4'd0,  8'h00, "mem0_untouched");
    read_chk(4'd9,  8'h5A, "read9");
  endtask

  task automatic test_hold();
    prog = 1'b1; ld_ptr = 1'b1; addr = 4'd2;
    tick();
    ld_ptr = 1'b0;
    wr_data = 8'h11; wr_stb = 1'b1;
    tick();
    // Changed data must never reach memory while the strobe stays high.
    wr_data = 8'h22;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (wr_ack !== 1'b1 || ptr !== 4'd3) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: ack=%b ptr=%0d, expected 1 3", i, wr_ack, ptr);
      end
      if (i < 4) tick();
    end
    wr_stb = 1'b0;
    tick();
    vectors++;
    if (wr_ack !== 1'b0 || ptr !== 4'd3) begin
      miscompares++;
      $display("FAIL hold_release: ack=%b ptr=%0d, expected 0 3", wr_ack, ptr);
    end
    read_chk(4'd3, 8'h00, "hold_no_second_write");
    read_chk(4'd2, 8'h11, "hold_single_write");
  endtask

  task automatic test_prog_ce();
    prog = 1'b1; ce = 1'b1; addr = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (ram_valid !== 1'b0 || ram_out !== 8'h11) begin
        miscompares++;
        $display("FAIL prog_ce%0d: out=%h valid=%b, expected 11 0", i, ram_out, ram_valid);
      end
    end
    ce = 1'b0;
    // Drop prog while in WR_HOLD (pointer is 3).
    wr_data = 8'h77; wr_stb = 1'b1;
    tick();
    vectors++;
    if (wr_ack !== 1'b1 || ptr !== 4'd4) begin
      miscompares++;
      $display("FAIL drop_write: ack=%b ptr=%0d, expected 1 4", wr_ack, ptr);
    end
    prog = 1'b0;
    tick();
    vectors++;
    if (wr_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_ack: ack=%b, expected 0", wr_ack);
    end
    // Strobe and pointer load are ignored in run mode.
    wr_stb = 1'b0;
    tick();
    wr_stb = 1'b1; ld_ptr = 1'b1; addr = 4'd9;
    tick();
    wr_stb = 1'b0; ld_ptr = 1'b0;
    vectors++;
    if (ptr !== 4'd4 || wr_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL run_ignores_loader: ptr=%0d ack=%b, expected 4 0", ptr, wr_ack);
    end
    read_chk(4'd3, 8'h77, "drop_write_persists");
    read_chk(4'd4, 8'h00, "run_no_write");
  endtask

  task automatic test_stream();
    prog = 1'b1; ld_ptr = 1'b1; addr = 4'd0;
    tick();
    ld_ptr = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'h10 + 8'(i));
    prog = 1'b0; ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 4'(i);
      tick();
      vectors++;
      if (ram_out !== 8'h10 + 8'(i) || ram_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stream%0d: out=%h valid=%b, expected %h 1", i, ram_out, ram_valid, 8'h10 + 8'(i));
      end
    end
    // Reset mid-stream while ce is still high at a loaded address.
    addr = 4'd1; rst_n = 1'b0;
    tick();
    vectors++;
    if (ram_out !== 8'h00 || ram_valid !== 1'b0 || ptr !== 4'd0) begin
      miscompares++;
      $display("FAIL stream_reset: out=%h valid=%b ptr=%0d, expected 00 0 0", ram_out, ram_valid, ptr);
    end
    rst_n = 1'b1;
    tick();
    ce = 1'b0;
    vectors++;
    if (ram_out !== 8'h00 || ram_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mem_cleared: out=%h valid=%b, expected 00 1", ram_out, ram_valid);
    end
  endtask

  task automatic test_reset_strobe_high();
    prog = 1'b1; wr_data = 8'h44; wr_stb = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    vectors++;
    if (wr_ack !== 1'b0 || ptr !== 4'd0) begin
      miscompares++;
      $display("FAIL stb_after_reset: ack=%b ptr=%0d, expected 0 0", wr_ack, ptr);
    end
    wr_stb = 1'b0;
    tick();
    wr_stb = 1'b1;
    tick();
    vectors++;
    if (wr_ack !== 1'b1 || ptr !== 4'd1) begin
      miscompares++;
      $display("FAIL stb_rearmed: ack=%b ptr=%0d, expected 1 1", wr_ack, ptr);
    end
    wr_stb = 1'b0;
    tick();
    read_chk(4'd0, 8'h44, "rearmed_data");
  endtask

`ifdef SAP_RAM_PARITY_EN
  task automatic test_parity();
    prog = 1'b1; ld_ptr = 1'b1; addr = 4'd5; par_inj = 1'b1;
    wr_data = 8'h07; wr_stb = 1'b1;
    tick();
    ld_ptr = 1'b0; wr_stb = 1'b0; par_inj = 1'b0;
    tick();
    read_chk(4'd5, 8'h07, "par_inj_data");
    vectors++;
    if (ram_perr !== 1'b1) begin
      miscompares++;
      $display("FAIL perr_injected: perr=%b, expected 1", ram_perr);
    end
    prog = 1'b1; ld_ptr = 1'b1; addr = 4'd5;
    wr_data = 8'h07; wr_stb = 1'b1;
    tick();
    ld_ptr = 1'b0; wr_stb = 1'b0;
    tick();
    read_chk(4'd5, 8'h07, "par_clean_data");
    vectors++;
    if (ram_perr !== 1'b0) begin
      miscompares++;
      $display("FAIL perr_clean: perr=%b, expected 0", ram_perr);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; prog = 1'b0; addr = '0; ce = 1'b0;
    ld_ptr = 1'b0; wr_stb = 1'b0; wr_data = '0;
`ifdef SAP_RAM_PARITY_EN
    par_inj = 1'b0;
`endif
    test_reset();
    test_load_wrap();
    test_hold();
    test_prog_ce();
    test_stream();
    test_reset_strobe_high();
`ifdef SAP_RAM_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
